// File: rtl/cache_traffic_gen_if.sv
// CPU-side memory port between the traffic generator and the cache stack.
// master: generator side (drives requests); slave: cache side (drives resp/rdata).
interface cache_traffic_gen_if;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/cache_traffic_gen.sv
// Seeded pseudo-random read/write traffic generator and read-back checker
// for the cache / cacheline_adaptor / ParamMemory stack.
// LFSR: 16-bit Fibonacci, taps 16,14,13,11 (shift right, feedback into bit 15).
// Optional feature macro CTG_PARTIAL_WRITE_EN: random byte strobes and
// per-byte shadow validity; otherwise full-word writes, one valid bit per word.
module cache_traffic_gen #(
    parameter int unsigned WINDOW_BITS = 4,
    parameter int unsigned NUM_OPS     = 64,
    parameter int unsigned WR_THRESH   = 6,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic                       MEM_CLK,
    input  logic                       rst,
    input  logic                       start,
    input  logic [31:0]                base_addr,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [15:0]                err_count,
    output logic [31:0]                first_err_addr,
    cache_traffic_gen_if.master        mem
);
    localparam int unsigned WORDS = 1 << WINDOW_BITS;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {S_IDLE, S_GAP, S_ISSUE, S_CHECK, S_DONE} state_t;
    state_t state, state_n;

    logic [15:0]            lfsr;
    logic [15:0]            lfsr_step;
    logic [15:0]            op_idx;
    logic [TO_W-1:0]        to_cnt;
    logic                   is_write;
    logic [WINDOW_BITS-1:0] idx;
    logic [31:0]            addr_q;
    logic [31:0]            wdata_q;
    logic [31:0]            rdata_q;
    logic [3:0]             be_q;
    logic [3:0]             strobe;
    logic [3:0]             byte_vld;
    logic [31:0]            cmp_mask;
    logic                   timed_out;
    logic                   last_op;
    logic                   wr_accept;
    logic                   to_hit;
    logic                   mismatch;
    logic [31:0]            shadow_data [WORDS];
`ifdef CTG_PARTIAL_WRITE_EN
    logic [WORDS-1:0][3:0]  shadow_vld;
`else
    logic [WORDS-1:0]       shadow_vld;
`endif

    // Next LFSR value, write strobes and the valid-byte masked read-back compare.
    always_comb begin
        lfsr_step = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
`ifdef CTG_PARTIAL_WRITE_EN
        strobe   = (lfsr_step[3:0] == 4'b0000) ? 4'b0001 : lfsr_step[3:0];
        byte_vld = shadow_vld[idx];
`else
        strobe   = '1;
        byte_vld = {4{shadow_vld[idx]}};
`endif
        cmp_mask = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            cmp_mask[8*b +: 8] = {8{byte_vld[b]}};
        end
        mismatch  = |((rdata_q ^ shadow_data[idx]) & cmp_mask);
        last_op   = (op_idx == 16'(NUM_OPS - 1));
        wr_accept = (state == S_ISSUE) && mem.mem_resp && is_write;
        to_hit    = (state == S_ISSUE) && !mem.mem_resp && (to_cnt == TO_W'(TIMEOUT));
    end

    // State register.
    always_ff @(posedge MEM_CLK) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    // Next-state logic and state-derived outputs.
    always_comb begin
        state_n                = state;
        busy                   = 1'b0;
        done                   = 1'b0;
        mem.mem_read           = 1'b0;
        mem.mem_write          = 1'b0;
        mem.mem_address        = addr_q;
        mem.mem_wdata          = wdata_q;
        mem.mem_byte_enable    = be_q;
        unique case (state)
            S_IDLE:  if (start) state_n = S_GAP;
            S_GAP: begin
                busy = 1'b1;
                if (!mem.mem_resp) state_n = S_ISSUE;
            end
            S_ISSUE: begin
                busy          = 1'b1;
                mem.mem_read  = !is_write;
                mem.mem_write = is_write;
                if (mem.mem_resp) begin
                    if (!is_write)    state_n = S_CHECK;
                    else if (last_op) state_n = S_DONE;
                    else              state_n = S_GAP;
                end else if (to_hit) begin
                    state_n = S_DONE;
                end
            end
            S_CHECK: begin
                busy    = 1'b1;
                state_n = last_op ? S_DONE : S_GAP;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_n = S_GAP;
            end
            default: state_n = S_IDLE;
        endcase
        pass = done && (err_count == '0) && !timed_out;
    end

    // Op generation, timeout tracking, error bookkeeping and shadow validity.
    always_ff @(posedge MEM_CLK) begin
        if (!rst) begin
            lfsr           <= LFSR_SEED;
            op_idx         <= '0;
            to_cnt         <= '0;
            is_write       <= 1'b0;
            idx            <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            be_q           <= '0;
            rdata_q        <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            timed_out      <= 1'b0;
            shadow_vld     <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        lfsr           <= LFSR_SEED;
                        op_idx         <= '0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        timed_out      <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (!mem.mem_resp) begin
                        lfsr     <= lfsr_step;
                        is_write <= 32'(lfsr_step[15:12]) < WR_THRESH;
                        idx      <= lfsr_step[WINDOW_BITS-1:0];
                        // Masking then adding the shifted offset equals adding to base_addr[31:2].
                        addr_q   <= (base_addr & 32'hFFFF_FFFC)
                                  + {{(30-WINDOW_BITS){1'b0}}, lfsr_step[WINDOW_BITS-1:0], 2'b00};
                        wdata_q  <= {lfsr_step, op_idx};
                        be_q     <= (32'(lfsr_step[15:12]) < WR_THRESH) ? strobe : 4'b0000;
                        to_cnt   <= '0;
                    end
                end
                S_ISSUE: begin
                    if (mem.mem_resp) begin
                        if (!is_write) rdata_q <= mem.mem_rdata;
                        if (is_write && !last_op) op_idx <= op_idx + 16'd1;
                    end else if (to_hit) begin
                        timed_out <= 1'b1;
                        if (err_count == '0) first_err_addr <= addr_q;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        if (err_count != '1) err_count <= err_count + 16'd1;
                        if (err_count == '0) first_err_addr <= addr_q;
                    end
                    if (!last_op) op_idx <= op_idx + 16'd1;
                end
                default: ;
            endcase
            if (wr_accept) begin
`ifdef CTG_PARTIAL_WRITE_EN
                shadow_vld[idx] <= shadow_vld[idx] | be_q;
`else
                shadow_vld[idx] <= 1'b1;
`endif
            end
        end
    end

    // Shadow data; contents are meaningful only where shadow_vld is set.
    always_ff @(posedge MEM_CLK) begin
        if (rst && wr_accept) begin
`ifdef CTG_PARTIAL_WRITE_EN
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_q[b]) shadow_data[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
`else
            shadow_data[idx] <= wdata_q;
`endif
        end
    end
endmodule

// File: tb/tb_cache_traffic_gen.sv
// Self-checking bench for cache_traffic_gen: behavioural memory with random
// latency, byte-level reference shadow, and per-op expected request stream.
module tb_cache_traffic_gen;
    localparam int unsigned NOPS = 64;
    localparam int unsigned WRT  = 8;
    localparam int unsigned TMO  = 15;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [31:0] BASE = 32'h0123_4000;

    logic MEM_CLK = 1'b0;
    always #5 MEM_CLK = ~MEM_CLK;

    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;

    cache_traffic_gen_if mem_if ();

    cache_traffic_gen #(
        .WINDOW_BITS (4),
        .NUM_OPS     (NOPS),
        .WR_THRESH   (WRT),
        .LFSR_SEED   (SEED),
        .TIMEOUT     (TMO)
    ) dut (
        .MEM_CLK        (MEM_CLK),
        .rst            (rst),
        .start          (start),
        .base_addr      (base_addr),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .mem            (mem_if)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference model state
    logic [15:0] m_lfsr;
    int unsigned k;
    int unsigned exp_err;
    logic [31:0] exp_first;
    logic [31:0] corrupt_addr;
    bit          hang;
    bit          corrupt_armed;
    logic [7:0]  mem_b    [logic [31:0]];
    logic [7:0]  shadow_b [logic [31:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] fb;
        fb = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 16'h0001;
        return (v >> 1) | (fb << 15);
    endfunction

    function automatic logic [3:0] exp_strobe(input logic [15:0] l);
`ifdef CTG_PARTIAL_WRITE_EN
        return (l[3:0] == 4'd0) ? 4'b0001 : l[3:0];
`else
        return 4'b1111;
`endif
    endfunction

    // Memory responder and per-cycle request checker.
    initial begin
        logic [15:0] l;
        logic        ewr;
        logic [31:0] eaddr;
        logic [31:0] ewd;
        logic [3:0]  ebe;
        logic [31:0] rd;
        logic [31:0] key;
        bit          written;
        bit          bad;
        int unsigned lat;
        mem_if.mem_resp  = 1'b0;
        mem_if.mem_rdata = '0;
        lat = 0;
        forever begin
            @(posedge MEM_CLK);
            #1;
            if (mem_if.mem_resp) begin
                mem_if.mem_resp = 1'b0;
                check("req_drop", {31'd0, mem_if.mem_read | mem_if.mem_write}, 32'd0);
            end else if (mem_if.mem_read || mem_if.mem_write) begin
                l     = lfsr_next(m_lfsr);
                ewr   = ({28'd0, l[15:12]} < WRT);
                eaddr = (base_addr & 32'hFFFF_FFFC) + 32'({l[3:0], 2'b00});
                ewd   = {l, k[15:0]};
                ebe   = exp_strobe(l);
                check("req_kind", {30'd0, mem_if.mem_read, mem_if.mem_write}, ewr ? 32'd1 : 32'd2);
                check("req_addr", mem_if.mem_address, eaddr);
                if (ewr) begin
                    check("req_be", {28'd0, mem_if.mem_byte_enable}, {28'd0, ebe});
                    check("req_wdata", mem_if.mem_wdata, ewd);
                end
                if (!hang) begin
                    if (lat != 0) begin
                        lat--;
                    end else begin
                        if (ewr) begin
                            for (int b = 0; b < 4; b++) begin
                                if (mem_if.mem_byte_enable[b])
                                    mem_b[mem_if.mem_address + 32'(b)] = mem_if.mem_wdata[8*b +: 8];
                                if (ebe[b]) shadow_b[eaddr + 32'(b)] = ewd[8*b +: 8];
                            end
                        end else begin
                            written = 0;
                            for (int b = 0; b < 4; b++) begin
                                key = mem_if.mem_address + 32'(b);
                                if (!mem_b.exists(key)) mem_b[key] = 8'($urandom);
                                rd[8*b +: 8] = mem_b[key];
                                if (shadow_b.exists(eaddr + 32'(b))) written = 1;
                            end
                            if (corrupt_armed && written) begin
                                rd[7:0]       = rd[7:0] ^ 8'hFF;
                                corrupt_armed = 0;
                                corrupt_addr  = eaddr;
                            end
                            bad = 0;
                            for (int b = 0; b < 4; b++) begin
                                key = eaddr + 32'(b);
                                if (shadow_b.exists(key) && shadow_b[key] !== rd[8*b +: 8]) bad = 1;
                            end
                            if (bad) begin
                                if (exp_err == 0) exp_first = eaddr;
                                exp_err++;
                            end
                            mem_if.mem_rdata = rd;
                        end
                        mem_if.mem_resp = 1'b1;
                        m_lfsr = l;
                        k++;
                        lat = $urandom_range(0, 3);
                    end
                end
            end
        end
    end

    task automatic model_new_run();
        m_lfsr    = SEED;
        k         = 0;
        exp_err   = 0;
        exp_first = '0;
    endtask

    task automatic pulse_start();
        @(negedge MEM_CLK);
        start = 1'b1;
        @(negedge MEM_CLK);
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"},  {31'd0, busy}, 32'd0);
        check({name, "_done"},  {31'd0, done}, 32'd0);
        check({name, "_pass"},  {31'd0, pass}, 32'd0);
        check({name, "_err"},   {16'd0, err_count}, 32'd0);
        check({name, "_first"}, first_err_addr, 32'd0);
        check({name, "_addr"},  mem_if.mem_address, 32'd0);
        check({name, "_rw"},    {30'd0, mem_if.mem_read, mem_if.mem_write}, 32'd0);
        check({name, "_be"},    {28'd0, mem_if.mem_byte_enable}, 32'd0);
        check({name, "_wdata"}, mem_if.mem_wdata, 32'd0);
    endtask

    task automatic wait_done(input string name, input int unsigned max);
        int unsigned n = 0;
        while (!done && n < max) begin
            @(negedge MEM_CLK);
            n++;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: done not seen within %0d cycles", name, max);
        end
    endtask

    task automatic wait_req(input string name, input int unsigned max);
        int unsigned n = 0;
        while (!(mem_if.mem_read || mem_if.mem_write) && n < max) begin
            @(negedge MEM_CLK);
            n++;
        end
        if (!(mem_if.mem_read || mem_if.mem_write)) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no request within %0d cycles", name, max);
        end
    endtask

    task automatic check_final(input string name);
        check({name, "_ops"},   k, NOPS);
        check({name, "_done"},  {31'd0, done}, 32'd1);
        check({name, "_busy"},  {31'd0, busy}, 32'd0);
        check({name, "_err"},   {16'd0, err_count}, exp_err);
        check({name, "_first"}, first_err_addr, exp_first);
        check({name, "_pass"},  {31'd0, pass}, (exp_err == 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int unsigned n;
        rst           = 1'b0;
        start         = 1'b1;
        base_addr     = BASE;
        hang          = 0;
        corrupt_armed = 0;
        corrupt_addr  = '0;
        model_new_run();

        // Reset held with start asserted
        repeat (5) begin
            @(negedge MEM_CLK);
            check_all_zero("reset");
        end
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) begin
            @(negedge MEM_CLK);
            check("idle_busy", {31'd0, busy}, 32'd0);
        end

        // Run A: normal traffic, a start pulse while busy must be ignored
        model_new_run();
        pulse_start();
        check("a_busy_after_start", {31'd0, busy}, 32'd1);
        wait_req("a_first_req", 20);
        check("a_op0_addr",  mem_if.mem_address, 32'h0123_4000);
        check("a_op0_write", {31'd0, mem_if.mem_write}, 32'd1);
        check("a_op0_wdata", mem_if.mem_wdata, 32'h5670_0000);
        repeat (10) @(negedge MEM_CLK);
        pulse_start();
        wait_done("a", 5000);
        check_final("a");

        // Run B: corrupt byte 0 of the first read of a previously written word
        model_new_run();
        corrupt_armed = 1;
        pulse_start();
        wait_done("b", 5000);
        check_final("b");
`ifndef CTG_PARTIAL_WRITE_EN
        check("b_err_lit",   {16'd0, err_count}, 32'd1);
        check("b_first_lit", first_err_addr, corrupt_addr);
        check("b_pass_lit",  {31'd0, pass}, 32'd0);
`endif

        // Run C: restart clears results, then reset mid-run
        model_new_run();
        pulse_start();
        check("c_clr_done",  {31'd0, done}, 32'd0);
        check("c_clr_err",   {16'd0, err_count}, 32'd0);
        check("c_clr_first", first_err_addr, 32'd0);
        repeat (25) @(negedge MEM_CLK);
        rst = 1'b0;
        @(negedge MEM_CLK);
        check_all_zero("midrst");
        rst = 1'b1;
        shadow_b.delete();
        model_new_run();

        // Run D: memory never responds
        hang = 1;
        pulse_start();
        wait_req("d_req", 20);
        n = 0;
        while (!done && n < 100) begin
            @(negedge MEM_CLK);
            n++;
        end
        check("d_timeout_cycles", n, 32'd16);
        check("d_pass",  {31'd0, pass}, 32'd0);
        check("d_first", first_err_addr, 32'h0123_4000);
        check("d_err",   {16'd0, err_count}, 32'd0);
        check("d_rw",    {30'd0, mem_if.mem_read, mem_if.mem_write}, 32'd0);
        check("d_busy",  {31'd0, busy}, 32'd0);

        // Run E: recovery after timeout
        hang = 0;
        model_new_run();
        pulse_start();
        wait_done("e", 5000);
        check_final("e");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
